// File: rtl/generic_phase_fifo_frame_align.sv
// Frame aligner for the phase-FIFO read side: hunts for a periodic marker, verifies it, then flywheels.
// Optional miss statistics counter is built when FRAME_ALIGN_MISS_CNT_EN is defined.
module generic_phase_fifo_frame_align #(
    parameter int              DW         = 20,
    parameter int              FRAME_LEN  = 16,
    parameter logic [DW-1:0]   MARKER     = 20'h5A5A5,
    parameter int              LOCK_CNT   = 3,
    parameter int              UNLOCK_CNT = 4,
    parameter int              CNT_W      = 8
) (
    input  logic               clk,
    input  logic               sreset,
    input  logic [DW-1:0]      din,
    output logic [DW-1:0]      dout,
    output logic               sof,
    output logic               locked,
    output logic [CNT_W-1:0]   lost_cnt,
    output logic [CNT_W-1:0]   miss_cnt_total
);

    localparam int PW = $clog2(FRAME_LEN);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);
    localparam logic [MW-1:0]    LOCK_V   = MW'(LOCK_CNT);
    localparam logic [UW-1:0]    UNLOCK_V = UW'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t           state, next_state;
    logic [PW-1:0]    pos, next_pos;
    logic [MW-1:0]    match_cnt, next_match_cnt;
    logic [UW-1:0]    miss_cnt, next_miss_cnt;
    logic             match;
    logic             at_slot;
    logic             sof_d, locked_d;
    logic [CNT_W-1:0] lost_d;

    assign match   = (din == MARKER);
    assign at_slot = (pos == '0);

    always_ff @(posedge clk) begin
        if (sreset) begin
            state     <= HUNT;
            pos       <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            dout      <= '0;
            sof       <= 1'b0;
            locked    <= 1'b0;
            lost_cnt  <= '0;
        end else begin
            state     <= next_state;
            pos       <= next_pos;
            match_cnt <= next_match_cnt;
            miss_cnt  <= next_miss_cnt;
            dout      <= din;
            sof       <= sof_d;
            locked    <= locked_d;
            lost_cnt  <= lost_d;
        end
    end

    // Markers are only judged at frame offset 0; a marker elsewhere is ordinary data.
    always_comb begin
        next_state     = state;
        next_pos       = pos + 1'b1;
        next_match_cnt = match_cnt;
        next_miss_cnt  = miss_cnt;
        case (state)
            HUNT: begin
                next_pos = '0;
                if (match) begin
                    next_state     = VERIFY;
                    next_pos       = PW'(1);
                    next_match_cnt = MW'(1);
                end
            end
            VERIFY: begin
                if (at_slot) begin
                    if (match) begin
                        next_match_cnt = match_cnt + 1'b1;
                        if (next_match_cnt == LOCK_V) begin
                            next_state    = LOCKED;
                            next_miss_cnt = '0;
                        end
                    end else begin
                        next_state = HUNT;
                        next_pos   = '0;
                    end
                end
            end
            LOCKED: begin
                if (at_slot) begin
                    if (match) begin
                        next_miss_cnt = '0;
                    end else begin
                        next_miss_cnt = miss_cnt + 1'b1;
                        if (next_miss_cnt == UNLOCK_V) begin
                            next_state = HUNT;
                            next_pos   = '0;
                        end
                    end
                end
            end
            default: begin
                next_state = HUNT;
                next_pos   = '0;
            end
        endcase
    end

    always_comb begin
        locked_d = (next_state == LOCKED);
        sof_d    = at_slot && locked_d;
        lost_d   = lost_cnt;
        if (state == LOCKED && next_state == HUNT && lost_cnt != CNT_MAX)
            lost_d = lost_cnt + 1'b1;
    end

`ifdef FRAME_ALIGN_MISS_CNT_EN
    logic [CNT_W-1:0] miss_total_q;
    logic             locked_miss;

    assign locked_miss = (state == LOCKED) && at_slot && !match;

    always_ff @(posedge clk) begin
        if (sreset)
            miss_total_q <= '0;
        else if (locked_miss && miss_total_q != CNT_MAX)
            miss_total_q <= miss_total_q + 1'b1;
    end

    assign miss_cnt_total = miss_total_q;
`else
    assign miss_cnt_total = '0;
`endif

endmodule

// File: tb/tb_generic_phase_fifo_frame_align.sv
// Directed bench for generic_phase_fifo_frame_align with a cycle-indexed behavioural model.
module tb_generic_phase_fifo_frame_align;

    localparam int          DW         = 20;
    localparam int          FRAME_LEN  = 16;
    localparam logic [19:0] MARKER     = 20'h5A5A5;
    localparam int          LOCK_CNT   = 3;
    localparam int          UNLOCK_CNT = 4;
    localparam int          CNT_W      = 8;
    localparam int          CNT_MAX    = 255;

    logic              clk;
    logic              sreset;
    logic [DW-1:0]     din;
    logic [DW-1:0]     dout;
    logic              sof;
    logic              locked;
    logic [CNT_W-1:0]  lost_cnt;
    logic [CNT_W-1:0]  miss_cnt_total;

    int checks_total  = 0;
    int checks_passed = 0;

    generic_phase_fifo_frame_align #(
        .DW(DW), .FRAME_LEN(FRAME_LEN), .MARKER(MARKER),
        .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .sreset(sreset), .din(din), .dout(dout), .sof(sof),
        .locked(locked), .lost_cnt(lost_cnt), .miss_cnt_total(miss_cnt_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            checks_passed++;
    endtask

    // Model: frame offset is (cycle - anchor) mod FRAME_LEN, anchor = cycle of the marker that left HUNT.
    int          cyc = 0, anchor = 0, mode = 0, good = 0, misses = 0, lost_m = 0, mtot_m = 0;
    logic [19:0] exp_dout;
    bit          exp_sof, exp_locked, model_valid = 0, hit, slot;

    always @(posedge clk) begin
        cyc++;
        if (sreset) begin
            mode = 0; good = 0; misses = 0; lost_m = 0; mtot_m = 0;
            exp_dout = '0; exp_sof = 0; exp_locked = 0;
            model_valid = 1;
        end else begin
            hit  = (din == MARKER);
            slot = (mode == 0) || (((cyc - anchor) % FRAME_LEN) == 0);
            exp_dout = din;
            case (mode)
                0: if (hit) begin mode = 1; anchor = cyc; good = 1; end
                1: if (slot) begin
                       if (hit) begin
                           good++;
                           if (good == LOCK_CNT) begin mode = 2; misses = 0; end
                       end else mode = 0;
                   end
                default: if (slot) begin
                       if (hit) misses = 0;
                       else begin
                           misses++;
                           if (mtot_m < CNT_MAX) mtot_m++;
                           if (misses == UNLOCK_CNT) begin
                               mode = 0;
                               if (lost_m < CNT_MAX) lost_m++;
                           end
                       end
                   end
            endcase
            exp_locked = (mode == 2);
            exp_sof    = slot && (mode == 2);
        end
    end

    function automatic int expMissTotal(input int v);
`ifdef FRAME_ALIGN_MISS_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("model_dout", 32'(dout), 32'(exp_dout));
            checkOutput("model_sof", 32'(sof), 32'(exp_sof));
            checkOutput("model_locked", 32'(locked), 32'(exp_locked));
            checkOutput("model_lost_cnt", 32'(lost_cnt), 32'(lost_m));
            checkOutput("model_miss_total", 32'(miss_cnt_total), 32'(expMissTotal(mtot_m)));
        end
    end

    function automatic logic [19:0] nonMarker();
        logic [19:0] w;
        w = 20'($urandom);
        if (w == MARKER) w = w ^ 20'h1;
        return w;
    endfunction

    // Present one word; returns just after the edge that consumed it, so outputs reflect it.
    task automatic applyStimulus(input logic rst, input logic [19:0] word);
        @(negedge clk);
        sreset = rst;
        din    = word;
        @(posedge clk);
        #1;
    endtask

    task automatic filler(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, nonMarker());
    endtask

    task automatic acquire();
        applyStimulus(1'b0, MARKER); filler(15);
        applyStimulus(1'b0, MARKER); filler(15);
        applyStimulus(1'b0, MARKER);
    endtask

    bit pattern [6] = '{0, 0, 1, 0, 0, 0};

    initial begin
        sreset = 1'b1;
        din    = '0;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, nonMarker());
            checkOutput("rst_dout", 32'(dout), 0);
            checkOutput("rst_sof", 32'(sof), 0);
            checkOutput("rst_locked", 32'(locked), 0);
            checkOutput("rst_lost", 32'(lost_cnt), 0);
        end
        applyStimulus(1'b0, 20'h12345);
        checkOutput("first_dout", 32'(dout), 32'h12345);
        filler(4);

        // Acquire lock on three spaced markers
        applyStimulus(1'b0, MARKER); filler(15);
        applyStimulus(1'b0, MARKER);
        checkOutput("verify_not_locked", 32'(locked), 0);
        filler(15);
        applyStimulus(1'b0, MARKER);
        checkOutput("lock_locked", 32'(locked), 1);
        checkOutput("lock_sof", 32'(sof), 1);
        checkOutput("lock_dout", 32'(dout), 32'h5A5A5);
        filler(15);
        applyStimulus(1'b0, MARKER);
        checkOutput("next_sof", 32'(sof), 1);
        applyStimulus(1'b0, nonMarker());
        checkOutput("sof_one_cycle", 32'(sof), 0);
        filler(14);

        // Flywheel through three misses, drop on the fourth
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, nonMarker());
            checkOutput("fly_locked", 32'(locked), 1);
            checkOutput("fly_sof", 32'(sof), 1);
            filler(15);
        end
        applyStimulus(1'b0, nonMarker());
        checkOutput("drop_locked", 32'(locked), 0);
        checkOutput("drop_sof", 32'(sof), 0);
        checkOutput("drop_lost", 32'(lost_cnt), 1);
        checkOutput("drop_miss_total", 32'(miss_cnt_total), 32'(expMissTotal(4)));

        // Off-slot marker is ignored, missing slot returns to HUNT, later marker restarts
        filler(3);
        applyStimulus(1'b0, MARKER); filler(9);
        applyStimulus(1'b0, MARKER); filler(5);
        applyStimulus(1'b0, nonMarker());
        checkOutput("offslot_locked", 32'(locked), 0);
        filler(3);
        acquire();
        checkOutput("relock_locked", 32'(locked), 1);
        checkOutput("relock_sof", 32'(sof), 1);
        filler(15);

        // Miss 2, hit 1, miss 3: lock holds
        foreach (pattern[j]) begin
            applyStimulus(1'b0, pattern[j] ? MARKER : nonMarker());
            checkOutput("mix_locked", 32'(locked), 1);
            filler(15);
        end
        checkOutput("mix_miss_total", 32'(miss_cnt_total), 32'(expMissTotal(9)));
        applyStimulus(1'b0, nonMarker());
        checkOutput("drop2_locked", 32'(locked), 0);
        checkOutput("drop2_lost", 32'(lost_cnt), 2);

        // Reset while locked, then relock from scratch
        filler(2);
        acquire();
        filler(5);
        applyStimulus(1'b1, nonMarker());
        checkOutput("mid_rst_locked", 32'(locked), 0);
        checkOutput("mid_rst_lost", 32'(lost_cnt), 0);
        checkOutput("mid_rst_dout", 32'(dout), 0);
        checkOutput("mid_rst_miss_total", 32'(miss_cnt_total), 0);
        applyStimulus(1'b0, MARKER); filler(15);
        applyStimulus(1'b0, MARKER);
        checkOutput("post_rst_two_markers", 32'(locked), 0);
        filler(15);
        applyStimulus(1'b0, MARKER);
        checkOutput("post_rst_locked", 32'(locked), 1);
        filler(3);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
